// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: owner encoding, bus request bundle
// and helpers that build the registered bus request for each port.
package mem_port_arbiter_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    typedef struct packed {
        logic   we;
        wrstb_t wrstb;
        u32_t   addr;
        u32_t   wdata;
    } mem_req_t;

    // Fetch is always a plain read.
    function automatic mem_req_t make_fetch_req(u32_t addr);
        mem_req_t r;
        r       = '0;
        r.addr  = addr;
        return r;
    endfunction

    // Reads never drive byte strobes onto the bus.
    function automatic mem_req_t make_data_req(logic we, wrstb_t wrstb, u32_t addr, u32_t wdata);
        mem_req_t r;
        r.we    = we;
        r.wrstb = we ? wrstb : '0;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between fetch and data ports, one outstanding transaction.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       i_req,
    input  u32_t       i_addr,
    output logic       i_ack,
    output u32_t       i_rdata,

    input  logic       d_req,
    input  logic       d_we,
    input  wrstb_t     d_wrstb,
    input  u32_t       d_addr,
    input  u32_t       d_wdata,
    output logic       d_ack,
    output u32_t       d_rdata,

    output logic       bus_req,
    output logic       bus_we,
    output wrstb_t     bus_wrstb,
    output u32_t       bus_addr,
    output u32_t       bus_wdata,
    input  logic       bus_ack,
    input  u32_t       bus_rdata,

    output arb_owner_t owner
);

    arb_owner_t owner_q, owner_d;
    mem_req_t   bus_q, bus_d;
    logic       bus_req_q, bus_req_d;
    logic       grant_i, grant_d;
    logic       force_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned StreakW = $clog2(STREAK_MAX + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STREAK_MAX);

    logic [StreakW-1:0] streak_q, streak_d;

    // Counts data grants that bypassed a waiting fetch; at the limit fetch takes the next slot.
    always_comb begin
        force_i  = i_req && d_req && (streak_q == StreakMax);
        streak_d = streak_q;
        if (owner_q == OWN_NONE) begin
            if (!i_req || grant_i) begin
                streak_d = '0;
            end else if (grant_d) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_streak_max;

    assign force_i           = 1'b0;
    assign unused_streak_max = ^STREAK_MAX;
`endif

    assign grant_d = (owner_q == OWN_NONE) && d_req && !force_i;
    assign grant_i = (owner_q == OWN_NONE) && i_req && !grant_d;

    always_comb begin
        owner_d   = owner_q;
        bus_d     = bus_q;
        bus_req_d = bus_req_q;
        case (owner_q)
            OWN_NONE: begin
                if (grant_d) begin
                    owner_d   = OWN_D;
                    bus_d     = make_data_req(d_we, d_wrstb, d_addr, d_wdata);
                    bus_req_d = 1'b1;
                end else if (grant_i) begin
                    owner_d   = OWN_I;
                    bus_d     = make_fetch_req(i_addr);
                    bus_req_d = 1'b1;
                end
            end
            OWN_I, OWN_D: begin
                // Bus fields keep their last values after completion; only bus_req drops.
                if (bus_ack) begin
                    owner_d   = OWN_NONE;
                    bus_req_d = 1'b0;
                end
            end
            default: begin
                owner_d   = OWN_NONE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            bus_q     <= '0;
            bus_req_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            bus_q     <= bus_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_q.we;
    assign bus_wrstb = bus_q.wrstb;
    assign bus_addr  = bus_q.addr;
    assign bus_wdata = bus_q.wdata;
    assign owner     = owner_q;

    assign i_ack   = bus_ack && (owner_q == OWN_I);
    assign d_ack   = bus_ack && (owner_q == OWN_D);
    assign i_rdata = (owner_q == OWN_I) ? bus_rdata : '0;
    assign d_rdata = (owner_q == OWN_D) ? bus_rdata : '0;

endmodule
